// File: rtl/alias_lane_packer_if.sv
// Handshake bundle for alias_lane_packer: narrow input stream in, packed wide word out.
// The master modport is the producer/consumer side; the slave modport is the packer.
interface alias_lane_packer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_data;
  logic                    in_last;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [IN_W*RATIO-1:0]   out_data;
  logic [RATIO-1:0]        out_keep;
  logic                    out_last;
  logic [CNT_W-1:0]        word_cnt;

  modport master (
    output in_valid, in_data, in_last, flush, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, word_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, word_cnt
  );
endinterface

// File: rtl/alias_lane_packer.sv
// Upsizing gearbox: packs RATIO IN_W-bit beats into one lane-sliced wide word,
// with early close on in_last/flush, per-lane keep mask and a saturating word counter.
module alias_lane_packer #(
  parameter int IN_W      = 32,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alias_lane_packer_if.slave bus
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;

  generate
    if (IN_W < 1 || RATIO < 2) begin : g_bad_params
      $error("alias_lane_packer: IN_W must be >= 1 and RATIO must be >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] mask;
  logic [IDX_W-1:0] idx;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [RATIO-1:0] out_keep_q;
  logic             out_last_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic             ready_c;
  logic             accept_c;
  logic             close_c;
  logic [IDX_W-1:0] lane_c;
  logic [OUT_W-1:0] acc_nx_c;
  logic [RATIO-1:0] mask_nx_c;

  assign ready_c  = !out_valid_q || bus.out_ready;
  assign accept_c = bus.in_valid && ready_c;
  assign lane_c   = (MSB_FIRST != 0) ? IDX_W'(RATIO - 1) - idx : idx;

  // Accumulator and mask as they stand after this cycle's beat, used both to
  // continue filling and as the closing word.
  always_comb begin
    acc_nx_c  = acc;
    mask_nx_c = mask;
    if (accept_c) begin
      acc_nx_c[int'(lane_c)*IN_W +: IN_W] = bus.in_data;
      mask_nx_c[lane_c]                    = 1'b1;
    end
    close_c = (accept_c && (idx == IDX_W'(RATIO - 1) || bus.in_last)) ||
              (bus.flush && ready_c && (mask != '0 || accept_c));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      mask        <= '0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (close_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_nx_c;
        out_keep_q  <= mask_nx_c;
        out_last_q  <= accept_c && bus.in_last;
        acc         <= '0;
        mask        <= '0;
        idx         <= '0;
        if (word_cnt_q != '1) begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
      end else if (accept_c) begin
        acc  <= acc_nx_c;
        mask <= mask_nx_c;
        idx  <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_alias_lane_packer.sv
// Bench for alias_lane_packer: an LSB-first packer and an MSB-first packer with a
// 3-bit counter share one stimulus stream and are checked against a queue-based model.
module tb_alias_lane_packer;

  localparam int IN_W  = 32;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [IN_W-1:0] in_data;
  logic in_last;
  logic flush;
  logic out_ready;

  int n_checks;
  int n_pass;

  alias_lane_packer_if #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(16)) if0 ();
  alias_lane_packer_if #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(3))  if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.in_last   = in_last;
  assign if0.flush     = flush;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.in_last   = in_last;
  assign if1.flush     = flush;
  assign if1.out_ready = out_ready;

  alias_lane_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  alias_lane_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: beats of the word being filled, plus the presented output word.
  logic [IN_W-1:0]  q[$];
  logic             m_valid;
  logic             m_last;
  logic [OUT_W-1:0] m_data[2];
  logic [RATIO-1:0] m_keep[2];
  logic [15:0]      m_cnt0;
  logic [2:0]       m_cnt1;

  task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_step();
    logic rdy;
    logic acc;
    int   lane;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_cnt0  = '0;
      m_cnt1  = '0;
      for (int d = 0; d < 2; d++) begin
        m_data[d] = '0;
        m_keep[d] = '0;
      end
    end else begin
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc) q.push_back(in_data);
      if ((acc && (q.size() == RATIO || in_last)) || (flush && rdy && q.size() != 0)) begin
        for (int d = 0; d < 2; d++) begin
          m_data[d] = '0;
          m_keep[d] = '0;
          for (int k = 0; k < q.size(); k++) begin
            lane = (d == 1) ? RATIO - 1 - k : k;
            m_data[d][lane*IN_W +: IN_W] = q[k];
            m_keep[d][lane] = 1'b1;
          end
        end
        m_last  = acc && in_last;
        m_valid = 1'b1;
        if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
        if (m_cnt1 != 3'd7)     m_cnt1 = m_cnt1 + 3'd1;
        q.delete();
      end
    end
  endtask

  // One clock: drive inputs, check combinational ready, advance model and DUTs, compare.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic l,
                       input logic f, input logic ordy, input logic rn);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    flush     = f;
    out_ready = ordy;
    rst_n     = rn;
    #1;
    if (rn) begin
      check("in_ready0", OUT_W'(if0.in_ready), OUT_W'(!m_valid || ordy));
      check("in_ready1", OUT_W'(if1.in_ready), OUT_W'(!m_valid || ordy));
    end
    model_step();
    @(posedge clk);
    #1;
    check("valid0", OUT_W'(if0.out_valid), OUT_W'(m_valid));
    check("valid1", OUT_W'(if1.out_valid), OUT_W'(m_valid));
    check("data0",  if0.out_data, m_data[0]);
    check("data1",  if1.out_data, m_data[1]);
    check("keep0",  OUT_W'(if0.out_keep), OUT_W'(m_keep[0]));
    check("keep1",  OUT_W'(if1.out_keep), OUT_W'(m_keep[1]));
    check("last0",  OUT_W'(if0.out_last), OUT_W'(m_last));
    check("last1",  OUT_W'(if1.out_last), OUT_W'(m_last));
    check("cnt0",   OUT_W'(if0.word_cnt), OUT_W'(m_cnt0));
    check("cnt1",   OUT_W'(if1.word_cnt), OUT_W'(m_cnt1));
  endtask

  initial begin
    logic [OUT_W-1:0] held0;
    logic [OUT_W-1:0] held1;
    logic [IN_W-1:0]  w;
    n_checks = 0;
    n_pass   = 0;
    q.delete();
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_cnt0  = '0;
    m_cnt1  = '0;
    m_data[0] = '0; m_data[1] = '0;
    m_keep[0] = '0; m_keep[1] = '0;
    in_valid = 0; in_data = '0; in_last = 0; flush = 0; out_ready = 1; rst_n = 0;
    @(posedge clk);
    #1;

    // Reset state
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 0, 0, 1, 0);
    check("rst_valid", OUT_W'(if0.out_valid), '0);
    check("rst_data",  if0.out_data, '0);
    check("rst_cnt",   OUT_W'(if1.word_cnt), '0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", OUT_W'(if0.in_ready), OUT_W'(1));

    // Full word, both lane orders
    cycle(1, 32'h11111111, 0, 0, 1, 1);
    cycle(1, 32'h22222222, 0, 0, 1, 1);
    cycle(1, 32'h33333333, 0, 0, 1, 1);
    cycle(1, 32'h44444444, 0, 0, 1, 1);
    check("full_lsb", if0.out_data, 128'h44444444_33333333_22222222_11111111);
    check("full_msb", if1.out_data, 128'h11111111_22222222_33333333_44444444);
    check("full_keep", OUT_W'(if0.out_keep), OUT_W'(4'hF));
    check("full_last", OUT_W'(if0.out_last), '0);
    check("full_cnt",  OUT_W'(if0.word_cnt), OUT_W'(1));

    // Partial word closed by in_last, then next beat starts at lane 0
    cycle(1, 32'hAAAAAAAA, 0, 0, 1, 1);
    cycle(1, 32'hBBBBBBBB, 1, 0, 1, 1);
    check("part_data", if0.out_data, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    check("part_keep", OUT_W'(if0.out_keep), OUT_W'(4'h3));
    check("part_last", OUT_W'(if0.out_last), OUT_W'(1));
    cycle(1, 32'hCCCCCCCC, 0, 0, 1, 1);
    cycle(0, '0, 0, 1, 1, 1);
    check("lane0_lsb", if0.out_data, 128'h00000000_00000000_00000000_CCCCCCCC);
    check("lane0_msb", if1.out_data, 128'hCCCCCCCC_00000000_00000000_00000000);
    check("lane0_keep", OUT_W'(if1.out_keep), OUT_W'(4'h8));

    // Backpressure: word held stable, input stalled, then back-to-back words
    cycle(0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'h50 + 32'(i), 0, 0, 0, 1);
    held0 = if0.out_data;
    held1 = if1.out_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h60, 0, 0, 0, 1);
      check("bp_ready", OUT_W'(if0.in_ready), '0);
      check("bp_hold0", if0.out_data, held0);
      check("bp_hold1", if1.out_data, held1);
    end
    for (int i = 0; i < 4; i++) cycle(1, 32'h60 + 32'(i), 0, 0, 1, 1);
    check("b2b_valid", OUT_W'(if0.out_valid), OUT_W'(1));
    check("b2b_data",  if0.out_data, 128'h00000063_00000062_00000061_00000060);

    // Flush of a partial word, then idle flush with nothing buffered
    cycle(0, '0, 0, 0, 1, 1);
    cycle(1, 32'h1, 0, 0, 1, 1);
    cycle(1, 32'h2, 0, 0, 1, 1);
    cycle(1, 32'h3, 0, 0, 1, 1);
    cycle(0, '0, 0, 1, 1, 1);
    check("fl_data", if0.out_data, 128'h00000000_00000003_00000002_00000001);
    check("fl_keep", OUT_W'(if0.out_keep), OUT_W'(4'h7));
    check("fl_last", OUT_W'(if0.out_last), '0);
    cycle(0, '0, 0, 1, 1, 1);
    cycle(0, '0, 0, 1, 1, 1);
    check("idle_fl", OUT_W'(if0.out_valid), '0);

    // Reset mid-word discards the partial word and the counter
    cycle(1, 32'hEEEEEEEE, 0, 0, 1, 1);
    cycle(1, 32'hEEEEEEEE, 0, 0, 1, 1);
    cycle(1, 32'hFFFFFFFF, 0, 1, 1, 0);
    check("mrst_data", if0.out_data, '0);
    check("mrst_cnt",  OUT_W'(if0.word_cnt), '0);
    for (int i = 0; i < 4; i++) cycle(1, 32'hD0 + 32'(i), 0, 0, 1, 1);
    check("mrst_word", if0.out_data, 128'h000000D3_000000D2_000000D1_000000D0);
    check("mrst_keep", OUT_W'(if0.out_keep), OUT_W'(4'hF));
    check("mrst_cnt1", OUT_W'(if0.word_cnt), OUT_W'(1));

    // Ten more words: 3-bit counter must saturate at 7
    for (int i = 0; i < 40; i++) cycle(1, $urandom, 0, 0, 1, 1);
    check("sat_cnt1", OUT_W'(if1.word_cnt), OUT_W'(3'd7));
    check("sat_cnt0", OUT_W'(if0.word_cnt), OUT_W'(11));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 299) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
